// File: rtl/mem_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_share_ctrl_pkg
// Shared constants for the two-port memory sharing controller:
//   state_t    - sequencer states (IDLE, ACCESS, DONE)
//   ROM_LIMIT  - first SRAM address; everything below it is ROM
//   GNT_A/B    - requester identifiers used by the arbiter and sequencer
// ---------------------------------------------------------------------------
package mem_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [6:0] ROM_LIMIT = 7'h40;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage : mem_share_ctrl_pkg

// File: rtl/mem_share_ctrl_arb.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter.
//   req_a, req_b : requests from A and B
//   last         : requester that was granted most recently (GNT_A / GNT_B)
//   gnt_valid    : at least one request is present
//   gnt_id       : winner; on a tie the requester that is not 'last' wins
// ---------------------------------------------------------------------------
module rr_arb2
  import mem_share_ctrl_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = GNT_A;
    if (req_a && req_b) begin
      gnt_id = ~last;
    end else if (req_b) begin
      gnt_id = GNT_B;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_share_ctrl.sv
// ---------------------------------------------------------------------------
// mem_share_ctrl
// Serialises read/write requests from two requesters (A, B) onto a single
// memory port with round-robin fairness and optional ROM write protection.
// Each transaction takes three cycles: IDLE (grant) -> ACCESS -> DONE, with
// the ack pulse appearing in the cycle after DONE's closing edge.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   requester A command (held until a_ack)
//   a_ack/a_err/a_rdata         requester A completion, error, read data
//   b_*                         same for requester B
//   mem_we/mem_addr/mem_din     memory command (registered)
//   mem_dout                    memory read data (combinational from mem_addr)
//   busy                        high whenever the sequencer is not in IDLE
// ---------------------------------------------------------------------------
module mem_share_ctrl
  import mem_share_ctrl_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter bit ROM_WP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ROM_LIMIT_W = ADDR_W'(ROM_LIMIT);

  state_t state_reg;
  logic   last_grant_reg;
  logic   gnt_id_reg;
  logic   err_q_reg;
  logic   we_q_reg;

  logic              arb_gnt_valid;
  logic              arb_gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_protect;

  rr_arb2 u_arb (
    .req_a     (a_req),
    .req_b     (b_req),
    .last      (last_grant_reg),
    .gnt_valid (arb_gnt_valid),
    .gnt_id    (arb_gnt_id)
  );

  // Command fields of whichever requester the arbiter picks this cycle.
  // Only sampled in IDLE, so a waiting requester's fields are never used.
  always_comb begin
    sel_we      = (arb_gnt_id == GNT_B) ? b_we    : a_we;
    sel_addr    = (arb_gnt_id == GNT_B) ? b_addr  : a_addr;
    sel_wdata   = (arb_gnt_id == GNT_B) ? b_wdata : a_wdata;
    sel_protect = ROM_WP && sel_we && (sel_addr < ROM_LIMIT_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_B;   // A wins the first tie after reset
      gnt_id_reg     <= GNT_A;
      err_q_reg      <= 1'b0;
      we_q_reg       <= 1'b0;
      a_ack          <= 1'b0;
      a_err          <= 1'b0;
      a_rdata        <= '0;
      b_ack          <= 1'b0;
      b_err          <= 1'b0;
      b_rdata        <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      busy           <= 1'b0;
    end else begin
      // Ack/err are single-cycle pulses; only DONE raises them.
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (arb_gnt_valid) begin
            gnt_id_reg <= arb_gnt_id;
            mem_addr   <= sel_addr;
            mem_din    <= sel_wdata;
            mem_we     <= sel_we & ~sel_protect;
            err_q_reg  <= sel_protect;
            we_q_reg   <= sel_we;
            busy       <= 1'b1;
            state_reg  <= ACCESS;
          end else begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
          end
        end

        ACCESS: begin
          // Write commits in the memory at this edge; reads capture here.
          // A rejected write is always a write, so it never touches rdata.
          if (!we_q_reg && !err_q_reg) begin
            if (gnt_id_reg == GNT_B) begin
              b_rdata <= mem_dout;
            end else begin
              a_rdata <= mem_dout;
            end
          end
          mem_we         <= 1'b0;
          last_grant_reg <= gnt_id_reg;
          busy           <= 1'b1;
          state_reg      <= DONE;
        end

        DONE: begin
          if (gnt_id_reg == GNT_B) begin
            b_ack <= 1'b1;
            b_err <= err_q_reg;
          end else begin
            a_ack <= 1'b1;
            a_err <= err_q_reg;
          end
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_share_ctrl

// File: tb/tb_mem_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_share_ctrl
// Self-checking bench for mem_share_ctrl. A behavioural model (memory image,
// last-grant flag, expected rdata per port) predicts grant order, ack cycle,
// err and read data for each batch of requests. A second instance with
// ROM_WP=0 checks that ROM writes are forwarded when protection is off.
// ---------------------------------------------------------------------------
module tb_mem_share_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Protected instance
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_we, busy;
  logic [6:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  // Unprotected instance (only port A used)
  logic       c_req = 1'b0, c_we = 1'b0;
  logic [6:0] c_addr = '0;
  logic [7:0] c_wdata = '0;
  logic       c_ack, c_err, c_b_ack, c_b_err, c_mem_we, c_busy;
  logic [7:0] c_rdata, c_b_rdata, c_mem_din, c_mem_dout;
  logic [6:0] c_mem_addr;

  mem_share_ctrl #(.ADDR_W(7), .DATA_W(8), .ROM_WP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  mem_share_ctrl #(.ADDR_W(7), .DATA_W(8), .ROM_WP(1'b0)) u_dut_nwp (
    .clk(clk), .rst_n(rst_n),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
    .a_ack(c_ack), .a_err(c_err), .a_rdata(c_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(7'h00), .b_wdata(8'h00),
    .b_ack(c_b_ack), .b_err(c_b_err), .b_rdata(c_b_rdata),
    .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_din(c_mem_din),
    .mem_dout(c_mem_dout), .busy(c_busy)
  );

  // Memory contents: ROM starts with a Fibonacci run, the rest is a pattern.
  function automatic logic [7:0] init_val(input int i);
    logic [7:0] fib [0:7];
    fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
    if (i < 8)       return fib[i];
    else if (i < 64) return 8'(i * 3 + 1);
    else             return 8'(i ^ 8'h5A);
  endfunction

  // Environment memory: ROM ignores writes, SRAM commits on the clock edge.
  logic [7:0] mem [0:127];
  initial for (int i = 0; i < 128; i++) mem[i] = init_val(i);
  always @(posedge clk) if (mem_we && mem_addr >= 7'h40) mem[mem_addr] <= mem_din;
  assign mem_dout   = mem[mem_addr];
  assign c_mem_dout = init_val(int'(c_mem_addr));

  // Count cycles with mem_we high (and illegal ROM writes on the protected DUT)
  int we_cnt = 0, rom_we_cnt = 0, c_we_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_we && mem_addr < 7'h40) rom_we_cnt <= rom_we_cnt + 1;
    if (c_mem_we) c_we_cnt <= c_we_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [7:0] ref_mem [0:127];
  bit         m_last;            // 0 = A, 1 = B
  logic [7:0] exp_a_rd, exp_b_rd;

  // Pending transaction for each requester
  bit         ta_en, ta_we, tb_en, tb_we;
  logic [6:0] ta_addr, tb_addr;
  logic [7:0] ta_wd, tb_wd;

  task automatic model_reset();
    m_last   = 1'b1;
    exp_a_rd = 8'h00;
    exp_b_rd = 8'h00;
  endtask

  // Issue the pending A/B transactions together (caller is #1 after a posedge,
  // DUT idle) and check grant order, ack timing, err, rdata and mem_we usage.
  task automatic run_txns(input string tag);
    bit         ord [2];
    bit         we_l [2];
    bit         err_l [2];
    logic [6:0] ad_l [2];
    logic [7:0] wd_l [2];
    logic [7:0] rda_l [2];
    logic [7:0] rdb_l [2];
    int n = 0, got = 0, exp_we = 0, we0, rom0, k;
    bit p;

    if (ta_en && tb_en) begin
      ord[0] = ~m_last;
      ord[1] = m_last;
      n = 2;
    end else begin
      ord[0] = tb_en;
      n = (ta_en || tb_en) ? 1 : 0;
    end
    for (int j = 0; j < n; j++) begin
      p        = ord[j];
      we_l[j]  = p ? tb_we   : ta_we;
      ad_l[j]  = p ? tb_addr : ta_addr;
      wd_l[j]  = p ? tb_wd   : ta_wd;
      err_l[j] = we_l[j] && (ad_l[j] < 7'h40);
      if (!we_l[j]) begin
        if (p) exp_b_rd = ref_mem[ad_l[j]];
        else   exp_a_rd = ref_mem[ad_l[j]];
      end else if (!err_l[j]) begin
        ref_mem[ad_l[j]] = wd_l[j];
        exp_we++;
      end
      rda_l[j] = exp_a_rd;
      rdb_l[j] = exp_b_rd;
      m_last   = p;
    end

    we0  = we_cnt;
    rom0 = rom_we_cnt;
    a_req = ta_en; a_we = ta_we; a_addr = ta_addr; a_wdata = ta_wd;
    b_req = tb_en; b_we = tb_we; b_addr = tb_addr; b_wdata = tb_wd;

    for (int cyc = 1; cyc <= 8 && got < n; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || cyc == 4) begin
        k = (cyc == 1) ? 0 : 1;
        if (k < n) begin
          n_cmp++;
          if (mem_addr !== ad_l[k] || mem_din !== wd_l[k] ||
              mem_we !== (we_l[k] && !err_l[k]) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s access%0d: addr=%h din=%h we=%b busy=%b, want addr=%h din=%h we=%b busy=1",
                     tag, k, mem_addr, mem_din, mem_we, busy, ad_l[k], wd_l[k], we_l[k] && !err_l[k]);
          end
        end
      end
      n_cmp++;
      if ((a_err && !a_ack) || (b_err && !b_ack)) begin
        n_err++;
        $display("FAIL %s err_without_ack cyc%0d: a_err=%b a_ack=%b b_err=%b b_ack=%b, want err only with ack",
                 tag, cyc, a_err, a_ack, b_err, b_ack);
      end
      if (a_ack || b_ack) begin
        n_cmp++;
        p = b_ack;
        if (a_ack && b_ack) begin
          n_err++;
          $display("FAIL %s dual_ack cyc%0d: both acks high, want one", tag, cyc);
        end else if (p !== ord[got] || cyc != 3 * (got + 1) ||
                     (p ? b_err : a_err) !== err_l[got] ||
                     a_rdata !== rda_l[got] || b_rdata !== rdb_l[got]) begin
          n_err++;
          $display("FAIL %s ack%0d: port=%0d cyc=%0d err=%b a_rd=%h b_rd=%h, want port=%0d cyc=%0d err=%b a_rd=%h b_rd=%h",
                   tag, got, p, cyc, p ? b_err : a_err, a_rdata, b_rdata,
                   ord[got], 3 * (got + 1), err_l[got], rda_l[got], rdb_l[got]);
        end
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
        got++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    n_cmp++;
    if (got != n) begin
      n_err++;
      $display("FAIL %s timeout: acks=%0d, want %0d", tag, got, n);
    end
    n_cmp++;
    if ((we_cnt - we0) != exp_we || rom_we_cnt != rom0) begin
      n_err++;
      $display("FAIL %s mem_we_cycles: got=%0d rom=%0d, want %0d rom=0",
               tag, we_cnt - we0, rom_we_cnt - rom0, exp_we);
    end
  endtask

  task automatic set_a(input bit en, input bit we, input logic [6:0] ad, input logic [7:0] wd);
    ta_en = en; ta_we = we; ta_addr = ad; ta_wd = wd;
  endtask

  task automatic set_b(input bit en, input bit we, input logic [6:0] ad, input logic [7:0] wd);
    tb_en = en; tb_we = we; tb_addr = ad; tb_wd = wd;
  endtask

  task automatic test_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h44; a_wdata = 8'hEE;
    b_req = 1'b1; b_we = 1'b1; b_addr = 7'h48; b_wdata = 8'hDD;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_ports: a=%b/%b/%h b=%b/%b/%h, want all 0",
               a_ack, a_err, a_rdata, b_ack, b_err, b_rdata);
    end
    n_cmp++;
    if ({mem_we, mem_addr, mem_din, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: we=%b addr=%h din=%h busy=%b, want all 0",
               mem_we, mem_addr, mem_din, busy);
    end
    rst_n = 1'b1;
    model_reset();
    set_a(1, 0, 7'h03, 8'h11);
    set_b(1, 0, 7'h46, 8'h22);
    run_txns("reset_release");
  endtask

  task automatic test_single_read();
    set_a(1, 0, 7'h05, 8'h9C);
    set_b(0, 0, 7'h00, 8'h00);
    run_txns("single_read");
    n_cmp++;
    if (a_rdata !== 8'd8) begin
      n_err++;
      $display("FAIL single_read_value: a_rdata=%0d, want 8", a_rdata);
    end
  endtask

  task automatic test_write_read();
    set_a(0, 0, 7'h00, 8'h00);
    set_b(1, 1, 7'h45, 8'hA5);
    run_txns("b_write_45");
    set_b(1, 0, 7'h45, 8'h00);
    run_txns("b_read_45");
    n_cmp++;
    if (b_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL b_read_value: b_rdata=%h, want a5", b_rdata);
    end
  endtask

  task automatic test_contention();
    set_a(1, 0, 7'h02, 8'h00);
    set_b(1, 0, 7'h47, 8'h00);
    run_txns("contend_1");
    set_a(1, 0, 7'h07, 8'h00);
    set_b(1, 0, 7'h45, 8'h00);
    run_txns("contend_2");
  endtask

  task automatic test_write_protect();
    set_a(1, 1, 7'h10, 8'h77);
    set_b(0, 0, 7'h00, 8'h00);
    run_txns("rom_write");
    set_a(1, 0, 7'h10, 8'h00);
    run_txns("rom_readback");
    n_cmp++;
    if (a_rdata !== init_val(16)) begin
      n_err++;
      $display("FAIL rom_readback_value: a_rdata=%h, want %h", a_rdata, init_val(16));
    end
  endtask

  task automatic test_no_protect();
    int  w0;
    bit  done = 0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 7'h10; c_wdata = 8'h77;
    w0 = c_we_cnt;
    for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        n_cmp++;
        if (c_mem_we !== 1'b1 || c_mem_addr !== 7'h10 || c_mem_din !== 8'h77) begin
          n_err++;
          $display("FAIL nwp_access: we=%b addr=%h din=%h, want 1/10/77", c_mem_we, c_mem_addr, c_mem_din);
        end
      end
      if (c_ack) begin
        n_cmp++;
        if (cyc != 3 || c_err !== 1'b0) begin
          n_err++;
          $display("FAIL nwp_ack: cyc=%0d err=%b, want cyc=3 err=0", cyc, c_err);
        end
        c_req = 1'b0;
        done  = 1;
      end
    end
    c_req = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL nwp_timeout: no ack, want ack");
    end
    n_cmp++;
    if (c_we_cnt - w0 != 1) begin
      n_err++;
      $display("FAIL nwp_we_cycles: got=%0d, want 1", c_we_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_op();
    b_req = 1'b1; b_we = 1'b1; b_addr = 7'h45; b_wdata = 8'h33;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_we !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midop_access: mem_we=%b busy=%b, want 1/1", mem_we, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || b_ack !== 1'b0) begin
      n_err++;
      $display("FAIL midop_async: mem_we=%b busy=%b b_ack=%b, want 0/0/0", mem_we, busy, b_ack);
    end
    b_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (b_ack !== 1'b0 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL midop_hold%0d: b_ack=%b mem_we=%b, want 0/0", i, b_ack, mem_we);
      end
    end
    rst_n = 1'b1;
    model_reset();
    set_a(1, 0, 7'h45, 8'h00);
    set_b(1, 0, 7'h46, 8'h00);
    run_txns("after_midop_reset");
  endtask

  task automatic test_random();
    string tag;
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(1, 3);
      set_a(sel[0], $urandom_range(0, 1) == 1,
            7'(($urandom_range(0, 1) == 1 ? 7'h40 : 7'h00) | 7'($urandom_range(0, 7))),
            8'($urandom));
      set_b(sel[1], $urandom_range(0, 1) == 1,
            7'(($urandom_range(0, 1) == 1 ? 7'h40 : 7'h00) | 7'($urandom_range(0, 7))),
            8'($urandom));
      tag = $sformatf("rand%0d", i);
      run_txns(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    model_reset();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_write_protect();
    test_no_protect();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_share_ctrl
